// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-requester round-robin arbiter with registered one-hot grant.
// Optional macro ARB_TIMEOUT_EN enables the MAX_HOLD forced-revoke logic.
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req[7:0]    level-sensitive request vector
//   grant[7:0]  registered grant, one-hot or zero
//   grant_valid registered, high when grant is non-zero
//   timeout     registered one-cycle pulse on forced revoke (0 when macro absent)
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic       grant_valid,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [7:0] LIM = 8'(MAX_HOLD - 1);
  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] grant_q, grant_d;
  logic [7:0] hold_q, hold_d;
  logic       gv_q, timeout_q, timeout_d;
  logic [7:0] pick;
  logic [2:0] own;
  logic       own_req;
  logic       found;
  logic [2:0] j;
  // First set request scanning circularly upward from ptr_q.
  always_comb begin
    pick = 8'h00;
    found = 1'b0;
    j = 3'd0;
    for (int i = 0; i < 8; i++) begin
      j = ptr_q + 3'(i);
      if (!found && req[j]) begin
        pick[j] = 1'b1;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    own = 3'd0;
    for (int i = 0; i < 8; i++) if (grant_q[i]) own = 3'(i);
  end
  assign own_req = |(req & grant_q);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    hold_d = hold_q;
    timeout_d = 1'b0;
    if (state_q == IDLE) begin
      if (found) begin
        grant_d = pick;
        hold_d = 8'd0;
        state_d = GRANT;
      end
    end else if (!own_req || (TO_EN && hold_q == LIM)) begin
      // Release takes precedence: timeout only flags when the owner still requests.
      timeout_d = own_req;
      grant_d = 8'h00;
      ptr_d = own + 3'd1;
      state_d = IDLE;
    end else begin
      hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= 3'd0;
      grant_q <= 8'h00;
      hold_q <= 8'd0;
      gv_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      hold_q <= hold_d;
      gv_q <= |grant_d;
      timeout_q <= timeout_d;
    end
  end
  assign grant = grant_q;
  assign grant_valid = gv_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: table, directed and random checks of rr_arbiter8 against a reference model.
module tb_rr_arbiter8;
  localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic       grant_valid, timeout;
  int vectors = 0;
  int miscompares = 0;
  int m_owner, m_ptr, m_held;
  bit m_to;
  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
  } vec_t;
  vec_t tbl[16];
  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant), .grant_valid(grant_valid), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] m_grant();
    return (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
  endfunction
  task automatic m_reset();
    m_owner = -1;
    m_ptr = 0;
    m_held = 0;
    m_to = 0;
  endtask
  task automatic m_update(input logic [7:0] r);
    m_to = 0;
    if (m_owner < 0) begin
      for (int i = 0; i < 8; i++)
        if (m_owner < 0 && r[(m_ptr + i) % 8]) begin
          m_owner = (m_ptr + i) % 8;
          m_held = 1;
        end
    end else if (!r[m_owner]) begin
      m_ptr = (m_owner + 1) % 8;
      m_owner = -1;
    end else if (TO_ON && m_held == MH) begin
      m_ptr = (m_owner + 1) % 8;
      m_owner = -1;
      m_to = 1;
    end else begin
      m_held++;
    end
  endtask
  task automatic check_model(input string tag);
    chk({tag, ".grant"}, 32'(grant), 32'(m_grant()));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(m_grant() != 8'h00));
    chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    chk({tag, ".onehot"}, 32'($countones(grant) <= 1), 32'd1);
  endtask
  task automatic step(input logic [7:0] r, input string tag);
    req = r;
    @(posedge clk);
    m_update(r);
    #1;
    check_model(tag);
  endtask
  task automatic do_reset(input logic [7:0] r);
    req = r;
    rst_n = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    check_model("reset");
    rst_n = 1'b1;
  endtask
  initial begin
    logic [7:0] r;
    tbl[0]  = '{8'h05, 8'h01}; tbl[1]  = '{8'h05, 8'h01};
    tbl[2]  = '{8'h04, 8'h00}; tbl[3]  = '{8'h05, 8'h04};
    tbl[4]  = '{8'h05, 8'h04}; tbl[5]  = '{8'h01, 8'h00};
    tbl[6]  = '{8'h05, 8'h01}; tbl[7]  = '{8'h05, 8'h01};
    tbl[8]  = '{8'h04, 8'h00}; tbl[9]  = '{8'h40, 8'h40};
    tbl[10] = '{8'h81, 8'h00}; tbl[11] = '{8'h81, 8'h80};
    tbl[12] = '{8'h01, 8'h00}; tbl[13] = '{8'h81, 8'h01};
    tbl[14] = '{8'h00, 8'h00}; tbl[15] = '{8'h00, 8'h00};
    #2;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_valid", 32'(grant_valid), 32'h0);
    chk("reset_timeout", 32'(timeout), 32'h0);
    do_reset(8'hFF);
    step(8'hFF, "first_arb");
    chk("first_grant", 32'(grant), 32'h01);
    do_reset(8'h00);
    foreach (tbl[i]) begin
      step(tbl[i].r, "table");
      chk($sformatf("tbl%0d.grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("tbl%0d.valid", i), 32'(grant_valid), 32'(tbl[i].g != 8'h00));
    end
    do_reset(8'h00);
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 6; c++) begin
      step(8'h10, "to");
      chk($sformatf("to%0d.grant", c), 32'(grant), (c == 4) ? 32'h00 : 32'h10);
      chk($sformatf("to%0d.pulse", c), 32'(timeout), (c == 4) ? 32'h1 : 32'h0);
    end
`else
    for (int c = 0; c < 105; c++) begin
      step(8'h10, "hold");
      if (grant !== 8'h10 || timeout !== 1'b0) begin
        chk("hold.grant", 32'(grant), 32'h10);
        chk("hold.timeout", 32'(timeout), 32'h0);
      end
    end
    chk("hold_end", 32'(grant), 32'h10);
`endif
    do_reset(8'h00);
    step(8'h20, "mid");
    chk("mid.grant", 32'(grant), 32'h20);
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("mid_rst.grant", 32'(grant), 32'h0);
    chk("mid_rst.valid", 32'(grant_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h21, "post_rst");
    chk("post_rst.grant", 32'(grant), 32'h01);
    do_reset(8'h00);
    for (int c = 0; c < 3000; c++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 4) != 0) r[m_owner] = 1'b1;
      step(r, "rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-requester round-robin arbiter with a registered one-hot grant. It sits directly upstream of the 8-to-3 one-hot encoder: `grant` drives the encoder input, and `grant_valid` qualifies the encoder output. The arbiter holds a grant until the owner drops its request. It rotates priority so no requester starves, and it can optionally revoke a grant that has been held too long.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles before forced revoke. Legal range is 1..255. Used only when `ARB_TIMEOUT_EN` is defined.

- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `req` input 8: request vector, one bit per requester, level-sensitive.
- `grant` output 8: registered grant; one-hot or 8'h00, never multi-hot.
- `grant_valid` output 1: registered; high exactly when `grant` is non-zero.
- `timeout` output 1: registered one-cycle pulse on forced revoke.

## Operation
- State register has two states: IDLE and GRANT.
- Priority pointer `ptr` is 3-bit and reset to 0. Requester `ptr` has highest priority, then `ptr+1`, and so on mod 8, so 7 wraps to 0.
- **IDLE:**
  - If `req` is 8'h00, stay in IDLE with `grant` = 0.
  - Otherwise select the first set bit scanning circularly from `ptr`. Load `grant` with that one-hot value and go to GRANT. The hold counter clears to 0.
- **GRANT, owner k:**
  - Only `req[k]` is examined; other request bits are ignored.
  - `req[k]` = 1 and no timeout: hold `grant`, increment the hold counter.
  - `req[k]` = 0 (release): `grant` goes to 0, `ptr` goes to (k+1) mod 8, and the state goes to IDLE.
  - Timeout condition (macro only): `req[k]` = 1 and hold counter = `MAX_HOLD`-1. Then `grant` goes to 0, `ptr` goes to (k+1) mod 8, the state goes to IDLE, and `timeout` = 1 for that one cycle.
- Release and timeout in the same cycle: release wins and `timeout` stays 0.
- A revoked requester that keeps `req` high re-competes normally from IDLE.
- The hold counter is 8-bit unsigned and saturates at 255. It is never compared when the macro is absent.
- Reset in any state, including mid-grant, asynchronously clears:
  - `grant`, `grant_valid` and `timeout` to 0,
  - `ptr` to 0,
  - the hold counter to 0,
  - the state to IDLE.

## Timing
- Request-to-grant latency: `req` sampled high in IDLE at edge n gives `grant` valid after edge n.
- Release-to-regrant:
  - `req[k]` sampled low at edge m gives `grant` = 0 during cycle m+1 (the mandatory IDLE cycle).
  - The next grant appears after edge m+1.
- With `ARB_TIMEOUT_EN`, a continuously requesting owner sees `grant` high for exactly `MAX_HOLD` cycles. This is followed by one cycle of `grant` = 0 with `timeout` = 1.
- All outputs are registered; there are no combinational paths from `req` to any output.
- At reset deassertion, the first arbitration occurs at the first rising edge with `rst_n` high.

## Configuration
- The macro is `ARB_TIMEOUT_EN`.
- Defined: hold-counter comparison and forced revoke are compiled in, and `timeout` pulses as described.
- Undefined: no revoke logic exists, a grant is held until release regardless of duration, and `timeout` is tied to 0.

## Test plan
- **Reset:** `rst_n` = 0 with `req` = 8'hFF gives `grant` = 8'h00, `grant_valid` = 0 and `timeout` = 0. After `rst_n` rises, `grant` = 8'h01 one edge later.
- **Rotation:**
  - Stimulus: `req` = 8'h05. Each owner holds 2 cycles, drops its request for 1 cycle, then re-raises.
  - Response: grants alternate 8'h01, 8'h00, 8'h04, 8'h00, 8'h01, and are never multi-hot.
- **Wrap-around:** after a grant to requester 6 is released, `req` = 8'h81 gives 8'h80 first. After that release, it gives 8'h01 (`ptr` wraps 7 to 0).
- **Timeout (macro on, `MAX_HOLD` = 4):**
  - Stimulus: `req` = 8'h10 held constant.
  - Response: `grant` = 8'h10 for 4 cycles, then 1 cycle of 8'h00 with `timeout` = 1, then 8'h10 again.
- **No timeout (macro off):** the same stimulus holds `grant` = 8'h10 for 100+ cycles, and `timeout` is never 1.
- **Mid-grant reset:**
  - Stimulus: assert `rst_n` = 0 asynchronously between edges while `grant` = 8'h20.
  - Response: `grant` = 0 immediately, without waiting for a clock edge. After release, with `req` = 8'h21, the grant is 8'h01 (`ptr` = 0).
